// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with destination scoreboard.
//
// Three writeback sources (ALU, load unit, CSR unit) compete for the single
// register-file write port. Grants are round-robin and combinational. The
// winning transfer is registered onto the write port one cycle later. A
// 32-entry scoreboard tracks registers with a pending writeback: the issue
// stage claims a register, and the transfer that writes it releases it.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   req[2:0]        writeback request (0 ALU, 1 load, 2 CSR), held until granted
//   addr0..addr2    destination register per requester
//   data0..data2    write data per requester
//   gnt[2:0]        one-hot (or zero) grant, combinational
//   claim_en        reserve claim_addr for a future writeback
//   claim_addr      register being reserved
//   rf_we           register file write enable (registered)
//   rf_waddr        register file write address (registered)
//   rf_wdata        register file write data (registered)
//   busy[31:0]      scoreboard, bit i = register i has a pending writeback
//   claim_conflict  one-cycle pulse: claim hit a register that was already busy
module regfile_wb_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [4:0]       addr0,
    input  logic [4:0]       addr1,
    input  logic [4:0]       addr2,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [2:0]       gnt,
    input  logic             claim_en,
    input  logic [4:0]       claim_addr,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [31:0]      busy,
    output logic             claim_conflict
);

    logic [1:0]       ptr;
    logic [1:0]       ptr_next;
    logic             xfer;
    logic [4:0]       xfer_addr;
    logic [WIDTH-1:0] xfer_data;
    logic             claim_hit;
    logic             conflict_next;
    logic [31:0]      busy_q;
    logic [31:0]      busy_next;

    // Round-robin search starting at ptr. The unreachable value 3 behaves like 0.
    always_comb begin
        gnt = 3'b000;
        if (!rst) begin
            case (ptr)
                2'd1: begin
                    if      (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                2'd2: begin
                    if      (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                default: begin
                    if      (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    // gnt is only ever set for a requesting source, so any grant is a transfer.
    assign xfer = |gnt;

    always_comb begin
        xfer_addr = 5'd0;
        xfer_data = '0;
        ptr_next  = ptr;
        case (gnt)
            3'b001: begin
                xfer_addr = addr0;
                xfer_data = data0;
                ptr_next  = 2'd1;
            end
            3'b010: begin
                xfer_addr = addr1;
                xfer_data = data1;
                ptr_next  = 2'd2;
            end
            3'b100: begin
                xfer_addr = addr2;
                xfer_data = data2;
                ptr_next  = 2'd0;
            end
            default: ;
        endcase
    end

    assign claim_hit = claim_en && (claim_addr != 5'd0);

    // Release first, then claim, so a same-edge claim of the written register wins.
    always_comb begin
        busy_next = busy_q;
        if (xfer && (xfer_addr != 5'd0)) begin
            busy_next[xfer_addr] = 1'b0;
        end
        if (claim_hit) begin
            busy_next[claim_addr] = 1'b1;
        end
    end

    // A register released on this very edge is free, so claiming it is no conflict.
    assign conflict_next = claim_hit && busy_q[claim_addr] &&
                           !(xfer && (xfer_addr == claim_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= 2'd0;
            rf_we          <= 1'b0;
            rf_waddr       <= 5'd0;
            rf_wdata       <= '0;
            busy_q         <= 32'd0;
            claim_conflict <= 1'b0;
        end else begin
            ptr            <= ptr_next;
            // Transfers to x0 are consumed but never write the register file.
            rf_we          <= xfer && (xfer_addr != 5'd0);
            if (xfer) begin
                rf_waddr <= xfer_addr;
                rf_wdata <= xfer_data;
            end
            busy_q         <= {busy_next[31:1], 1'b0};
            claim_conflict <= conflict_next;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, then a random stress
// run checked cycle by cycle against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [4:0]  addr0, addr1, addr2;
    logic [31:0] data0, data1, data2;
    logic [2:0]  gnt;
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        claim_conflict;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .addr0          (addr0),
        .addr1          (addr1),
        .addr2          (addr2),
        .data0          (data0),
        .data1          (data1),
        .data2          (data2),
        .gnt            (gnt),
        .claim_en       (claim_en),
        .claim_addr     (claim_addr),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy),
        .claim_conflict (claim_conflict)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        cen;
        logic [4:0]  caddr;
        logic [2:0]  gnt;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic        conflict;
    } vec_t;

    vec_t vecs[17];

    // Stress model state
    logic [1:0]  m_ptr;
    logic [31:0] m_busy;
    logic        m_we, m_conf;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [2:0]  pend;
    logic [4:0]  p_addr[3];
    logic [31:0] p_data[3];
    int          wait_cnt[3];

    initial begin
        //             rst  req    a0 a1 a2 d0           d1            d2     cen caddr gnt    we waddr wdata          busy          conf
        vecs[0]  = '{1'b1, 3'b111, 5, 6, 7, 32'h11,      32'h22,       32'h33, 0, 0, 3'b000, 0, 0, 32'h0,         32'h0,        0};
        vecs[1]  = '{1'b0, 3'b111, 5, 6, 7, 32'h11,      32'h22,       32'h33, 0, 0, 3'b001, 1, 5, 32'h11,        32'h0,        0};
        vecs[2]  = '{1'b0, 3'b111, 5, 6, 7, 32'h11,      32'h22,       32'h33, 0, 0, 3'b010, 1, 6, 32'h22,        32'h0,        0};
        vecs[3]  = '{1'b0, 3'b111, 5, 6, 7, 32'h11,      32'h22,       32'h33, 0, 0, 3'b100, 1, 7, 32'h33,        32'h0,        0};
        vecs[4]  = '{1'b0, 3'b000, 0, 0, 0, 32'h0,       32'h0,        32'h0,  1, 9, 3'b000, 0, 7, 32'h33,        32'h200,      0};
        vecs[5]  = '{1'b0, 3'b010, 0, 9, 0, 32'h0,       32'hDEADBEEF, 32'h0,  0, 0, 3'b010, 1, 9, 32'hDEADBEEF,  32'h0,        0};
        vecs[6]  = '{1'b0, 3'b001, 0, 0, 0, 32'h1234,    32'h0,        32'h0,  0, 0, 3'b001, 0, 0, 32'h1234,      32'h0,        0};
        vecs[7]  = '{1'b0, 3'b111, 5, 6, 7, 32'h11,      32'h22,       32'h33, 0, 0, 3'b010, 1, 6, 32'h22,        32'h0,        0};
        vecs[8]  = '{1'b0, 3'b000, 0, 0, 0, 32'h0,       32'h0,        32'h0,  1, 4, 3'b000, 0, 6, 32'h22,        32'h10,       0};
        vecs[9]  = '{1'b0, 3'b001, 4, 0, 0, 32'h44,      32'h0,        32'h0,  1, 4, 3'b001, 1, 4, 32'h44,        32'h10,       0};
        vecs[10] = '{1'b0, 3'b000, 0, 0, 0, 32'h0,       32'h0,        32'h0,  1, 4, 3'b000, 0, 4, 32'h44,        32'h10,       1};
        vecs[11] = '{1'b0, 3'b000, 0, 0, 0, 32'h0,       32'h0,        32'h0,  0, 0, 3'b000, 0, 4, 32'h44,        32'h10,       0};
        vecs[12] = '{1'b0, 3'b000, 0, 0, 0, 32'h0,       32'h0,        32'h0,  1, 0, 3'b000, 0, 4, 32'h44,        32'h10,       0};
        vecs[13] = '{1'b0, 3'b100, 0, 0, 4, 32'h0,       32'h0,        32'h77, 1, 3, 3'b100, 1, 4, 32'h77,        32'h08,       0};
        vecs[14] = '{1'b0, 3'b001, 8, 0, 0, 32'h88,      32'h0,        32'h0,  0, 0, 3'b001, 1, 8, 32'h88,        32'h08,       0};
        vecs[15] = '{1'b1, 3'b101, 10, 0, 12, 32'h100,   32'h0,        32'h300, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,        0};
        vecs[16] = '{1'b0, 3'b101, 10, 0, 12, 32'h100,   32'h0,        32'h300, 0, 0, 3'b001, 1, 10, 32'h100,     32'h0,        0};

        rst = 1'b1; req = '0; addr0 = '0; addr1 = '0; addr2 = '0;
        data0 = '0; data1 = '0; data2 = '0; claim_en = 1'b0; claim_addr = '0;
        repeat (2) @(posedge clk);

        // Inputs change on the falling edge; gnt is checked before the rising
        // edge and the registered outputs just after it.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; req = vecs[i].req;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; addr2 = vecs[i].a2;
            data0 = vecs[i].d0; data1 = vecs[i].d1; data2 = vecs[i].d2;
            claim_en = vecs[i].cen; claim_addr = vecs[i].caddr;
            #1;
            check("gnt", i, {29'd0, gnt}, {29'd0, vecs[i].gnt});
            @(posedge clk);
            #1;
            check("rf_we", i, {31'd0, rf_we}, {31'd0, vecs[i].we});
            check("rf_waddr", i, {27'd0, rf_waddr}, {27'd0, vecs[i].waddr});
            check("rf_wdata", i, rf_wdata, vecs[i].wdata);
            check("busy", i, busy, vecs[i].busy);
            check("claim_conflict", i, {31'd0, claim_conflict}, {31'd0, vecs[i].conflict});
        end

        // Hand sequence: reset with a grant in flight, then no stray write.
        @(negedge clk);
        rst = 1'b0; req = 3'b000; claim_en = 1'b1; claim_addr = 5'd20;
        @(negedge clk);
        claim_en = 1'b0; req = 3'b010; addr1 = 5'd20; data1 = 32'hCAFE;
        rst = 1'b1;
        #1;
        check("seq_rst_gnt", 0, {29'd0, gnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req = 3'b000;
        check("seq_rst_we", 0, {31'd0, rf_we}, 32'd0);
        check("seq_rst_busy", 0, busy, 32'd0);
        @(negedge clk);
        check("seq_post_we", 0, {31'd0, rf_we}, 32'd0);

        // Random stress against the model. Requesters hold until granted.
        m_ptr = 0; m_busy = 0; m_we = 0; m_conf = 0; m_waddr = 0; m_wdata = 0;
        pend = 0;
        for (int k = 0; k < 3; k++) begin
            p_addr[k] = 0; p_data[k] = 0; wait_cnt[k] = 0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic [2:0]  e_gnt;
            int          g;
            logic [31:0] nb;
            int          mx;
            for (int k = 0; k < 3; k++) begin
                if (!pend[k] && ($urandom_range(1, 0) == 1)) begin
                    pend[k]   = 1'b1;
                    p_addr[k] = 5'($urandom_range(31, 0));
                    p_data[k] = $urandom;
                end
            end
            claim_en   = ($urandom_range(2, 0) == 0);
            claim_addr = 5'($urandom_range(31, 0));
            req = pend;
            addr0 = p_addr[0]; addr1 = p_addr[1]; addr2 = p_addr[2];
            data0 = p_data[0]; data1 = p_data[1]; data2 = p_data[2];

            g = -1;
            for (int i = 0; i < 3; i++) begin
                int k;
                k = (int'(m_ptr) + i) % 3;
                if (g < 0 && pend[k]) g = k;
            end
            e_gnt = (g < 0) ? 3'b000 : 3'(1 << g);
            #1;
            check("st_gnt", c, {29'd0, gnt}, {29'd0, e_gnt});

            nb = m_busy;
            m_we = 1'b0;
            m_conf = claim_en && claim_addr != 0 && m_busy[claim_addr] &&
                     !(g >= 0 && p_addr[g] == claim_addr);
            if (g >= 0) begin
                m_ptr   = 2'((g + 1) % 3);
                m_we    = (p_addr[g] != 0);
                m_waddr = p_addr[g];
                m_wdata = p_data[g];
                if (p_addr[g] != 0) nb[p_addr[g]] = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (k != g && pend[k]) wait_cnt[k]++;
                end
                wait_cnt[g] = 0;
                pend[g] = 1'b0;
            end
            if (claim_en && claim_addr != 0) nb[claim_addr] = 1'b1;
            m_busy = nb;
            mx = 0;
            for (int k = 0; k < 3; k++) if (wait_cnt[k] > mx) mx = wait_cnt[k];
            check("st_starve", c, {31'd0, mx > 2}, 32'd0);

            @(posedge clk);
            #1;
            check("st_we", c, {31'd0, rf_we}, {31'd0, m_we});
            check("st_waddr", c, {27'd0, rf_waddr}, {27'd0, m_waddr});
            check("st_wdata", c, rf_wdata, m_wdata);
            check("st_busy", c, busy, m_busy);
            check("st_conflict", c, {31'd0, claim_conflict}, {31'd0, m_conf});
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data width of every writeback source and of the register file write port.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  3  per-requester writeback request; bit 0 ALU, bit 1 load unit, bit 2 CSR unit.
REQ-005 addr0, addr1, addr2  input  5 each  destination register of requester 0/1/2.
REQ-006 data0, data1, data2  input  WIDTH each  write data of requester 0/1/2.
REQ-007 gnt  output  3  one-hot (or zero) grant, combinational from req and the priority pointer.
REQ-008 claim_en  input  1  issue stage reserves a destination register for a future writeback.
REQ-009 claim_addr  input  5  register being reserved.
REQ-010 rf_we  output  1  register file write enable, registered.
REQ-011 rf_waddr  output  5  register file write address, registered.
REQ-012 rf_wdata  output  WIDTH  register file write data, registered.
REQ-013 busy  output  32  scoreboard, bit i = register i has a pending writeback.
REQ-014 claim_conflict  output  1  registered one-cycle pulse: claim hit an already-busy register.

Function
REQ-015 Transfer on requester k = req[k] & gnt[k] sampled at a rising edge; at most one transfer per cycle.
REQ-016 gnt SHALL be round-robin: first requester with req set, searching ptr, ptr+1, ptr+2 (mod 3); gnt = 0 when req = 0 or rst = 1.
REQ-017 ptr (2 bits, legal values 0..2) SHALL update to (k+1) mod 3 after a transfer on k; holds when no transfer.
REQ-018 A requester not granted SHALL hold req, addr and data stable until granted; the block does not buffer ungranted requests.
REQ-019 Latency: rf_we/rf_waddr/rf_wdata SHALL reflect a transfer on the edge it occurs, i.e. visible one cycle after gnt was presented.
REQ-020 rf_we SHALL be 1 only for a transfer with addr != 0; a transfer to x0 is granted and consumed but rf_we = 0.
REQ-021 With no transfer, rf_we SHALL be 0 and rf_waddr/rf_wdata SHALL hold their previous values.
REQ-022 Claim: on an edge with claim_en = 1 and claim_addr != 0, busy[claim_addr] SHALL set to 1.
REQ-023 Transfer on register r != 0 SHALL clear busy[r] on the same edge.
REQ-024 Claim and transfer to the same register on the same edge: busy SHALL end at 1 (new claim wins).
REQ-025 Claim to a register already busy (and not cleared that edge) SHALL pulse claim_conflict for one cycle; busy stays 1.
REQ-026 busy[0] SHALL be constant 0; claims and transfers of x0 never change busy and never raise claim_conflict.
REQ-027 Claim and transfer to different registers on the same edge SHALL both take effect.

Reset
REQ-028 While rst = 1 at an edge: ptr = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy = 0, claim_conflict = 0.
REQ-029 Reset mid-operation SHALL discard any in-flight grant: gnt = 0 during rst, no transfer counted, no rf_we on the following cycle.
REQ-030 First cycle after reset release, requester 0 SHALL have highest priority.

Verification
REQ-031 Reset, then req = 3'b111 held 3 cycles with addr0/1/2 = 5/6/7 -> gnt 001, 010, 100; rf_waddr 5, 6, 7 one cycle later each, rf_we = 1.
REQ-032 claim_en, claim_addr = 9; next cycle req = 3'b010, addr1 = 9, data1 = 32'hDEADBEEF -> busy[9] = 1 then 0 after transfer; rf_wdata = 32'hDEADBEEF, rf_we = 1.
REQ-033 req = 3'b001, addr0 = 0, data0 = 32'h1234 -> gnt = 001, ptr -> 1, rf_we = 0, busy unchanged.
REQ-034 busy[4] = 1; same edge claim 4 and transfer to 4 -> busy[4] = 1, claim_conflict = 0; further claim 4 -> claim_conflict = 1 for one cycle.
REQ-035 req = 3'b101 with ptr = 1, rst asserted that cycle -> gnt = 0, rf_we = 0 next cycle, ptr = 0, busy = 0.
REQ-036 Random req/claim stress 10k cycles vs. reference model: gnt one-hot, no requester starved beyond 2 grants, busy matches model every cycle.
